// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU sequencer: state encoding, opcodes and
// the decoded control word. CPU_SINGLE_STEP_EN is consumed by cpu_sequencer.
package cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_EXEC0  = 3'd3,
    ST_EXEC1  = 3'd4,
    ST_EXEC2  = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef struct packed {
    logic pc_oe;
    logic ram_oe;
    logic ir_oe;
    logic a_oe;
    logic alu_oe;
    logic mar_ld;
    logic ir_ld;
    logic a_ld;
    logic b_ld;
    logic out_ld;
    logic pc_ld;
    logic pc_inc;
    logic ram_we;
    logic flags_ld;
    logic alu_sub;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(15'd0);

  // T-state index reported on the step output; RST and HALT read as 0
  function automatic logic [2:0] step_index(input state_t st);
    case (st)
      ST_FETCH0: step_index = 3'd0;
      ST_FETCH1: step_index = 3'd1;
      ST_EXEC0:  step_index = 3'd2;
      ST_EXEC1:  step_index = 3'd3;
      ST_EXEC2:  step_index = 3'd4;
      default:   step_index = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational control decoder: (state, opcode, flags, run) -> control strobes.
// With run low every strobe is forced to 0.
module cpu_ctrl_decode
  import cpu_pkg::*;
#(
  parameter int OPC_W = cpu_pkg::OPC_W
) (
  input  logic [2:0]       state,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_c,
  input  logic             flag_z,
  output logic             pc_oe,
  output logic             ram_oe,
  output logic             ir_oe,
  output logic             a_oe,
  output logic             alu_oe,
  output logic             mar_ld,
  output logic             ir_ld,
  output logic             a_ld,
  output logic             b_ld,
  output logic             out_ld,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             ram_we,
  output logic             flags_ld,
  output logic             alu_sub
);

  state_t     st_s;
  logic [3:0] op_s;
  ctrl_t      ctrl_s;

  assign st_s = state_t'(state);
  assign op_s = 4'(opcode);

  // Decode the control word for the current T-state and instruction
  always_comb begin
    ctrl_s = CTRL_NONE;
    if (run) begin
      case (st_s)
        ST_FETCH0: begin
          ctrl_s.pc_oe  = 1'b1;
          ctrl_s.mar_ld = 1'b1;
        end
        ST_FETCH1: begin
          ctrl_s.ram_oe = 1'b1;
          ctrl_s.ir_ld  = 1'b1;
          ctrl_s.pc_inc = 1'b1;
        end
        ST_EXEC0: begin
          case (op_s)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl_s.ir_oe  = 1'b1;
              ctrl_s.mar_ld = 1'b1;
            end
            OP_LDI: begin
              ctrl_s.ir_oe = 1'b1;
              ctrl_s.a_ld  = 1'b1;
            end
            OP_JMP: begin
              ctrl_s.ir_oe = 1'b1;
              ctrl_s.pc_ld = 1'b1;
            end
            OP_JC: begin
              ctrl_s.ir_oe = 1'b1;
              ctrl_s.pc_ld = flag_c;
            end
            OP_JZ: begin
              ctrl_s.ir_oe = 1'b1;
              ctrl_s.pc_ld = flag_z;
            end
            OP_OUT: begin
              ctrl_s.a_oe   = 1'b1;
              ctrl_s.out_ld = 1'b1;
            end
            default: ctrl_s = CTRL_NONE;
          endcase
        end
        ST_EXEC1: begin
          case (op_s)
            OP_LDA: begin
              ctrl_s.ram_oe = 1'b1;
              ctrl_s.a_ld   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl_s.ram_oe = 1'b1;
              ctrl_s.b_ld   = 1'b1;
            end
            OP_STA: begin
              ctrl_s.a_oe   = 1'b1;
              ctrl_s.ram_we = 1'b1;
            end
            default: ctrl_s = CTRL_NONE;
          endcase
        end
        ST_EXEC2: begin
          case (op_s)
            OP_ADD, OP_SUB: begin
              ctrl_s.alu_oe   = 1'b1;
              ctrl_s.a_ld     = 1'b1;
              ctrl_s.flags_ld = 1'b1;
              ctrl_s.alu_sub  = (op_s == OP_SUB);
            end
            default: ctrl_s = CTRL_NONE;
          endcase
        end
        default: ctrl_s = CTRL_NONE;
      endcase
    end else begin
      ctrl_s = CTRL_NONE;
    end
  end

  assign pc_oe    = ctrl_s.pc_oe;
  assign ram_oe   = ctrl_s.ram_oe;
  assign ir_oe    = ctrl_s.ir_oe;
  assign a_oe     = ctrl_s.a_oe;
  assign alu_oe   = ctrl_s.alu_oe;
  assign mar_ld   = ctrl_s.mar_ld;
  assign ir_ld    = ctrl_s.ir_ld;
  assign a_ld     = ctrl_s.a_ld;
  assign b_ld     = ctrl_s.b_ld;
  assign out_ld   = ctrl_s.out_ld;
  assign pc_ld    = ctrl_s.pc_ld;
  assign pc_inc   = ctrl_s.pc_inc;
  assign ram_we   = ctrl_s.ram_we;
  assign flags_ld = ctrl_s.flags_ld;
  assign alu_sub  = ctrl_s.alu_sub;

endmodule

// File: rtl/cpu_sequencer.sv
// T-state sequencer for a small accumulator CPU: state register, next-state logic
// and registered status. Define CPU_SINGLE_STEP_EN to add the step_req input.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPC_W = cpu_pkg::OPC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_c,
  input  logic             flag_z,
`ifdef CPU_SINGLE_STEP_EN
  input  logic             step_req,
`endif
  output logic             pc_oe,
  output logic             ram_oe,
  output logic             ir_oe,
  output logic             a_oe,
  output logic             alu_oe,
  output logic             mar_ld,
  output logic             ir_ld,
  output logic             a_ld,
  output logic             b_ld,
  output logic             out_ld,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             ram_we,
  output logic             flags_ld,
  output logic             alu_sub,
  output logic             halted,
  output logic             fetch,
  output logic [2:0]       step
);

  state_t     state_r;
  state_t     next_state_s;
  logic       go_s;
  logic [3:0] op_s;
  logic       halted_r;
  logic       fetch_r;
  logic [2:0] step_r;

  assign op_s = 4'(opcode);

`ifdef CPU_SINGLE_STEP_EN
  // FETCH0 is held (with controls off) until a step is requested
  assign go_s = ena & ((state_r != ST_FETCH0) | step_req);
`else
  assign go_s = ena;
`endif

  // Next-state: instructions leave straight after their last active T-state
  always_comb begin
    next_state_s = state_r;
    if (go_s) begin
      case (state_r)
        ST_RST:    next_state_s = ST_FETCH0;
        ST_FETCH0: next_state_s = ST_FETCH1;
        ST_FETCH1: next_state_s = ST_EXEC0;
        ST_EXEC0: begin
          case (op_s)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: next_state_s = ST_EXEC1;
            OP_HLT:                         next_state_s = ST_HALT;
            default:                        next_state_s = ST_FETCH0;
          endcase
        end
        ST_EXEC1: begin
          case (op_s)
            OP_ADD, OP_SUB: next_state_s = ST_EXEC2;
            default:        next_state_s = ST_FETCH0;
          endcase
        end
        ST_EXEC2:  next_state_s = ST_FETCH0;
        ST_HALT:   next_state_s = ST_HALT;
        default:   next_state_s = ST_RST;
      endcase
    end else begin
      next_state_s = state_r;
    end
  end

  // State register; status outputs are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_RST;
      halted_r <= 1'b0;
      fetch_r  <= 1'b0;
      step_r   <= 3'd0;
    end else begin
      state_r  <= next_state_s;
      halted_r <= (next_state_s == ST_HALT);
      fetch_r  <= (next_state_s == ST_FETCH0);
      step_r   <= step_index(next_state_s);
    end
  end

  assign halted = halted_r;
  assign fetch  = fetch_r;
  assign step   = step_r;

  cpu_ctrl_decode #(
    .OPC_W (OPC_W)
  ) u_decode (
    .state    (state_r),
    .run      (go_s),
    .opcode   (opcode),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .pc_oe    (pc_oe),
    .ram_oe   (ram_oe),
    .ir_oe    (ir_oe),
    .a_oe     (a_oe),
    .alu_oe   (alu_oe),
    .mar_ld   (mar_ld),
    .ir_ld    (ir_ld),
    .a_ld     (a_ld),
    .b_ld     (b_ld),
    .out_ld   (out_ld),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .ram_we   (ram_we),
    .flags_ld (flags_ld),
    .alu_sub  (alu_sub)
  );

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus randomized
// instruction streams with ena stalls, checked against a per-instruction step list.
module tb_cpu_sequencer;

  localparam logic [14:0] C_PC_OE    = 15'h4000;
  localparam logic [14:0] C_RAM_OE   = 15'h2000;
  localparam logic [14:0] C_IR_OE    = 15'h1000;
  localparam logic [14:0] C_A_OE     = 15'h0800;
  localparam logic [14:0] C_ALU_OE   = 15'h0400;
  localparam logic [14:0] C_MAR_LD   = 15'h0200;
  localparam logic [14:0] C_IR_LD    = 15'h0100;
  localparam logic [14:0] C_A_LD     = 15'h0080;
  localparam logic [14:0] C_B_LD     = 15'h0040;
  localparam logic [14:0] C_OUT_LD   = 15'h0020;
  localparam logic [14:0] C_PC_LD    = 15'h0010;
  localparam logic [14:0] C_PC_INC   = 15'h0008;
  localparam logic [14:0] C_RAM_WE   = 15'h0004;
  localparam logic [14:0] C_FLAGS_LD = 15'h0002;
  localparam logic [14:0] C_ALU_SUB  = 15'h0001;
  localparam logic [14:0] C_NONE     = 15'h0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;
`ifdef CPU_SINGLE_STEP_EN
  logic       step_req;
`endif
  logic pc_oe, ram_oe, ir_oe, a_oe, alu_oe;
  logic mar_ld, ir_ld, a_ld, b_ld, out_ld, pc_ld, pc_inc, ram_we, flags_ld, alu_sub;
  logic halted, fetch;
  logic [2:0] step;

  logic [14:0] ctrl_w;
  assign ctrl_w = {pc_oe, ram_oe, ir_oe, a_oe, alu_oe, mar_ld, ir_ld, a_ld, b_ld,
                   out_ld, pc_ld, pc_inc, ram_we, flags_ld, alu_sub};

  int n_cmp  = 0;
  int n_fail = 0;
  logic [14:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_sequencer #(.OPC_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .opcode   (opcode),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
`ifdef CPU_SINGLE_STEP_EN
    .step_req (step_req),
`endif
    .pc_oe    (pc_oe),
    .ram_oe   (ram_oe),
    .ir_oe    (ir_oe),
    .a_oe     (a_oe),
    .alu_oe   (alu_oe),
    .mar_ld   (mar_ld),
    .ir_ld    (ir_ld),
    .a_ld     (a_ld),
    .b_ld     (b_ld),
    .out_ld   (out_ld),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .ram_we   (ram_we),
    .flags_ld (flags_ld),
    .alu_sub  (alu_sub),
    .halted   (halted),
    .fetch    (fetch),
    .step     (step)
  );

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output mid-cycle, then move to just after the next rising edge
  task automatic check_cycle(input string tag, input logic [14:0] ec, input int es,
                             input logic ef, input logic eh);
    @(negedge clk);
    chk({tag, ".ctrl"},   ctrl_w,       ec);
    chk({tag, ".step"},   15'(step),    15'(es));
    chk({tag, ".fetch"},  15'(fetch),   15'(ef));
    chk({tag, ".halted"}, 15'(halted),  15'(eh));
    chk({tag, ".oe1"},
        15'($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) <= 1), 15'd1);
    @(posedge clk);
    #1;
  endtask

  // Reference: the ordered list of control words one instruction produces
  task automatic build_model(input logic [3:0] op, input logic fc, input logic fz);
    exp_q = {};
    exp_q.push_back(C_PC_OE | C_MAR_LD);
    exp_q.push_back(C_RAM_OE | C_IR_LD | C_PC_INC);
    case (op)
      4'h1: begin
        exp_q.push_back(C_IR_OE | C_MAR_LD);
        exp_q.push_back(C_RAM_OE | C_A_LD);
      end
      4'h2, 4'h3: begin
        exp_q.push_back(C_IR_OE | C_MAR_LD);
        exp_q.push_back(C_RAM_OE | C_B_LD);
        exp_q.push_back(C_ALU_OE | C_A_LD | C_FLAGS_LD | ((op == 4'h3) ? C_ALU_SUB : C_NONE));
      end
      4'h4: begin
        exp_q.push_back(C_IR_OE | C_MAR_LD);
        exp_q.push_back(C_A_OE | C_RAM_WE);
      end
      4'h5: exp_q.push_back(C_IR_OE | C_A_LD);
      4'h6: exp_q.push_back(C_IR_OE | C_PC_LD);
      4'h7: exp_q.push_back(C_IR_OE | (fc ? C_PC_LD : C_NONE));
      4'h8: exp_q.push_back(C_IR_OE | (fz ? C_PC_LD : C_NONE));
      4'hE: exp_q.push_back(C_A_OE | C_OUT_LD);
      default: exp_q.push_back(C_NONE);
    endcase
  endtask

  // Run one whole instruction, optionally stalling with ena=0 before a step
  task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz,
                           input int stall_step, input int stall_len, input bit rnd);
    build_model(op, fc, fz);
    flag_c = fc;
    flag_z = fz;
    opcode = rnd ? 4'($urandom_range(0, 15)) : op;
    for (int i = 0; i < exp_q.size(); i++) begin
      int ns;
      ns = 0;
      if (i == 1) opcode = op;
      if (i == stall_step) ns = stall_len;
      else if (rnd && ($urandom_range(0, 7) == 0)) ns = $urandom_range(1, 3);
      if (ns > 0) begin
        ena = 1'b0;
        repeat (ns) check_cycle($sformatf("stall_op%h_s%0d", op, i), C_NONE, i, i == 0, 1'b0);
        ena = 1'b1;
      end
      check_cycle($sformatf("op%h_s%0d", op, i), exp_q[i], i, i == 0, 1'b0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b0;
    opcode = 4'h0;
    flag_c = 1'b0;
    flag_z = 1'b0;
`ifdef CPU_SINGLE_STEP_EN
    step_req = 1'b1;
`endif
    #1;
    // Reset state, with ena both low and high
    check_cycle("rst0", C_NONE, 0, 1'b0, 1'b0);
    ena = 1'b1;
    check_cycle("rst1", C_NONE, 0, 1'b0, 1'b0);
    ena = 1'b0;
    rst_n = 1'b1;
    check_cycle("rst_idle0", C_NONE, 0, 1'b0, 1'b0);
    check_cycle("rst_idle1", C_NONE, 0, 1'b0, 1'b0);
    ena = 1'b1;
    check_cycle("rst_go", C_NONE, 0, 1'b0, 1'b0);

    // Directed: LDI, SUB, conditional jumps, ADD with a stall in EXEC1
    run_instr(4'h5, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'h3, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'h8, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'h8, 1'b0, 1'b1, -1, 0, 1'b0);
    run_instr(4'h7, 1'b1, 1'b0, -1, 0, 1'b0);
    run_instr(4'h7, 1'b0, 1'b1, -1, 0, 1'b0);
    run_instr(4'h2, 1'b0, 1'b0, 3, 3, 1'b0);
    run_instr(4'h0, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'hA, 1'b0, 1'b0, -1, 0, 1'b0);

    // Randomized instruction stream (no HLT) with random stalls
    for (int k = 0; k < 150; k++) begin
      run_instr(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1, 0, 1'b1);
    end

    // Reset in the middle of an ADD takes effect before the next edge
    opcode = 4'h2;
    check_cycle("mid_f0", C_PC_OE | C_MAR_LD, 0, 1'b1, 1'b0);
    check_cycle("mid_f1", C_RAM_OE | C_IR_LD | C_PC_INC, 1, 1'b0, 1'b0);
    rst_n = 1'b0;
    check_cycle("mid_rst", C_NONE, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check_cycle("mid_idle", C_NONE, 0, 1'b0, 1'b0);
    run_instr(4'h1, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'h4, 1'b0, 1'b0, -1, 0, 1'b0);
    run_instr(4'hE, 1'b0, 1'b0, -1, 0, 1'b0);

    // HLT is sticky whatever ena does; only reset leaves it
    run_instr(4'hF, 1'b0, 1'b0, -1, 0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      ena = 1'($urandom_range(0, 1));
      check_cycle("halt", C_NONE, 0, 1'b0, 1'b1);
    end
    ena = 1'b1;
    rst_n = 1'b0;
    check_cycle("halt_rst", C_NONE, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    check_cycle("halt_idle", C_NONE, 0, 1'b0, 1'b0);
    run_instr(4'h6, 1'b0, 1'b0, -1, 0, 1'b0);

`ifdef CPU_SINGLE_STEP_EN
    // Waits in FETCH0 without a request; a one-cycle pulse runs one LDA
    step_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check_cycle("ss_wait", C_NONE, 0, 1'b1, 1'b0);
    end
    build_model(4'h1, 1'b0, 1'b0);
    opcode = 4'h1;
    step_req = 1'b1;
    check_cycle("ss_s0", exp_q[0], 0, 1'b1, 1'b0);
    step_req = 1'b0;
    for (int i = 1; i < exp_q.size(); i++) begin
      check_cycle($sformatf("ss_s%0d", i), exp_q[i], i, 1'b0, 1'b0);
    end
    check_cycle("ss_wait2", C_NONE, 0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
